alu_mdu_ctrl: RTL

- Next-generation ALU control block for the RV32/RV64 core.
- Keeps the combinational R/I/load/store/branch/U/J decode to alu_op, using the existing 4-bit encoding 0..9.
- Adds RV M-extension decode and an iterative multiply/divide sequencer with valid/ready handshakes.
- Sits in the execute stage. The pipeline stalls on in_ready=0 and consumes the result through out_valid/out_ready.

---
 rtl/rv_pkg.sv | 47 ++++
 rtl/mdu_iter.sv | 101 ++++++++++
 rtl/alu_mdu_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV decode constants, ALU/M-op encodings and the M-sequencer state type.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator, one bit per step, sign fixup on the final step.
module mdu_iter
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  md_op_e               op_q;
  logic [XLEN-1:0]      mb_q;
  logic [2*XLEN-1:0]    acc_q;
  logic                 neg_q;
  logic [CNT_W-1:0]     cnt_q;

  md_op_e               op_in;
  logic                 sa, sb, neg_start;
  logic [XLEN-1:0]      ma, mb;

  logic [XLEN:0]        sum;
  logic [XLEN:0]        rsh;
  logic [XLEN+1:0]      diff;
  logic                 ge;
  logic [2*XLEN-1:0]    acc_mul, acc_div, acc_nx, prod_fix;
  logic [XLEN-1:0]      div_sel;

  assign op_in = md_op_e'(op);

  always_comb begin
    sa = (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a[XLEN-1];
    sb = (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) & b[XLEN-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    neg_start = 1'b0;
    case (op_in)
      MD_MUL, MD_MULH: neg_start = sa ^ sb;
      MD_MULHSU:       neg_start = sa;
      // a zero divisor must leave the all-ones quotient unnegated
      MD_DIV:          neg_start = (sa ^ sb) & (b != '0);
      MD_REM:          neg_start = sa;
      default:         neg_start = 1'b0;
    endcase
  end

  // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
  // Divide: low half holds the remaining dividend/quotient bits, high half the remainder.
  always_comb begin
    sum     = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mb_q})
                       : {1'b0, acc_q[2*XLEN-1:XLEN]};
    acc_mul = {sum, acc_q[XLEN-1:1]};
    rsh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = {1'b0, rsh} - {2'b00, mb_q};
    ge      = ~diff[XLEN+1];
    acc_div = {(ge ? diff[XLEN-1:0] : rsh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    acc_nx  = op_q[2] ? acc_div : acc_mul;
  end

  always_comb begin
    prod_fix = neg_q ? -acc_nx : acc_nx;
    div_sel  = (op_q inside {MD_DIV, MD_DIVU}) ? acc_nx[XLEN-1:0] : acc_nx[2*XLEN-1:XLEN];
    result   = '0;
    if (op_q[2])
      result = neg_q ? -div_sel : div_sel;
    else if (op_q == MD_MUL)
      result = prod_fix[XLEN-1:0];
    else
      result = prod_fix[2*XLEN-1:XLEN];
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= MD_MUL;
      mb_q  <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      op_q  <= op_in;
      mb_q  <= mb;
      acc_q <= {{XLEN{1'b0}}, ma};
      neg_q <= neg_start;
      cnt_q <= CNT_W'(XLEN - 1);
    end else if (step) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// Execute-stage ALU control: combinational ALU decode plus the M-extension
// sequencer FSM with valid/ready handshakes around mdu_iter.
module alu_mdu_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic [3:0]      alu_op,
  output logic            is_md,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result
);

  alu_op_e          op_d;
  md_state_e        state;
  logic             start, step, last;
  logic [XLEN-1:0]  iter_result;

  assign is_md = (opcode == OP_R) && (funct7 == F7_MULDIV);

  always_comb begin
    op_d = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        if (!is_md) begin
          case (funct3)
            3'b000: op_d = ((opcode == OP_R) && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b001: op_d = ALU_SLL;
            3'b010: op_d = ALU_SLT;
            3'b011: op_d = ALU_SLTU;
            3'b100: op_d = ALU_XOR;
            3'b101: op_d = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110: op_d = ALU_OR;
            default: op_d = ALU_AND;
          endcase
        end
      end
      OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: op_d = ALU_ADD;
      default: op_d = ALU_ADD;
    endcase
  end

  assign alu_op = op_d;

  assign start = (state == ST_IDLE) && in_valid && is_md && !flush;
  assign step  = (state == ST_MUL) || (state == ST_DIV);

  mdu_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .op     (funct3),
    .a      (rs1),
    .b      (rs2),
    .last   (last),
    .result (iter_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      md_result <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && is_md) begin
            state    <= funct3[2] ? ST_DIV : ST_MUL;
            in_ready <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (last) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            md_result <= iter_result;
          end
        end
        default: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
